fuc: RTL and testbench
======================

FUC -- requirements
Module: fuc

Interface
REQ-001 The block SHALL have parameter BW, default 12, giving the I/Q sample width in signed two's complement.
REQ-002 The block SHALL have parameter ABW, default 10, giving the NCO phase width as a fraction of a full circle (2^(ABW-1) = pi).
REQ-003 The block SHALL have port clk_fs, input, 1 bit: sampling clock; the only clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: baseband sample offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: baseband sample taken this cycle if in_valid is high.
REQ-007 The block SHALL have port Iin, input, BW bits: baseband I at fs/4.
REQ-008 The block SHALL have port Qin, input, BW bits: baseband Q at fs/4.
REQ-009 The block SHALL have port Wif, input, ABW bits: phase increment per clk_fs cycle, unsigned.
REQ-010 The block SHALL have port out_valid, output, 1 bit: Iout/Qout carry pipeline data.
REQ-011 The block SHALL have port Iout, output, BW bits: up-converted I at fs.
REQ-012 The block SHALL have port Qout, output, BW bits: up-converted Q at fs.
REQ-013 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when a zero sample was inserted.

Function
REQ-014 A 2-bit phase counter ph SHALL increment every cycle and wrap 3->0; in_ready SHALL be 1 exactly when ph==0.
REQ-015 At ph==0, in_valid=1 SHALL capture Iin/Qin into the input register; in_valid=0 SHALL capture 0/0 and pulse underrun the next cycle.
REQ-016 Interpolation stage 1 (x2) SHALL clock its 5-tap FIR on ph even: input = captured sample at ph==0, and 0 at ph==2.
REQ-017 Interpolation stage 2 (x2) SHALL clock its 5-tap FIR every cycle: input = stage-1 output on ph even, and 0 on ph odd.
REQ-018 Both FIRs SHALL use unsigned coefficients {211,420,503,420,211}; the accumulator SHALL be BW+14 bits.
REQ-019 Each FIR output SHALL be the accumulator arithmetically shifted right 11 (truncating), then multiplied by 2, saturated to BW bits, and registered.
REQ-020 NCO: theta (ABW bits) SHALL update as theta <= theta + Wif every cycle, modulo 2^ABW.
REQ-021 Gross rotation (registered) SHALL act on q = theta[ABW-1:ABW-2]: 00 -> (I,Q); 01 -> (-Q,I); 10 -> (-I,-Q); 11 -> (Q,-I).
REQ-022 Negating -2^(BW-1) SHALL saturate to 2^(BW-1)-1.
REQ-023 Fine rotation SHALL use 7 registered CORDIC stages i=0..6, with z0 = {2'b00, theta[ABW-3:0]}, where theta is the value used by the gross stage.
REQ-024 The CORDIC angle table SHALL be 128,76,40,20,10,5,3.
REQ-025 CORDIC stage i, for z>=0, SHALL compute x'=x-(y>>>i), y'=y+(x>>>i), z'=z-tan_i; for z<0 the signs SHALL be opposite.
REQ-026 The CORDIC datapath SHALL be BW+2 bits; the final x/y SHALL be saturated to BW bits and drive Iout/Qout.
REQ-027 CORDIC gain (~1.647) SHALL NOT be compensated.
REQ-028 Latency SHALL be 11 cycles: a sample captured at cycle 0 SHALL first affect Iout/Qout at cycle 11 (input 1 + FIR1 1 + FIR2 1 + gross 1 + CORDIC 7).
REQ-029 out_valid SHALL be 0 for the first 11 cycles after reset release and 1 thereafter until the next reset.
REQ-030 A change on Wif SHALL take effect on theta at the next cycle; no other interaction with the data path SHALL exist.

Reset
REQ-031 While rst=1 at a clk_fs edge, ph, theta, all FIR taps, all pipeline registers, Iout, Qout, out_valid, and underrun SHALL become 0.
REQ-032 During reset, in_ready SHALL be 0.
REQ-033 In the first cycle after rst falls, in_ready SHALL be 1.
REQ-034 Reset asserted mid-stream SHALL discard all in-flight samples, with no partial output after release.

Verification
REQ-035 Mid-stream rst held for 2 cycles -> Iout=Qout=0, out_valid=0, theta=0; in_ready=1 on the first cycle after release; out_valid rises 11 cycles later.
REQ-036 Wif=0, single accepted Iin=1024, Qin=0, then zeros -> first nonzero Iout exactly 11 cycles after capture; |Qout| <= 2% of peak |Iout|; response symmetric within +/-1 LSB.
REQ-037 in_valid=0 at a ph==0 slot -> underrun=1 for exactly one cycle, and the inserted sample is zero.
REQ-038 Iin=Qin=-2048 held continuously, with Wif=128 -> Iout/Qout stay within [-2048,2047]; no sign wrap is observed.
REQ-039 Wif=256 -> theta sequence 0,256,512,768,0 and the quadrant cycles 00,01,10,11; Wif=1023 -> theta decrements by 1 modulo 1024.
REQ-040 in_valid held high continuously -> exactly one acceptance every 4 cycles and no underrun pulses.

Source files
------------

// File: rtl/fuc.sv
// Digital up-converter: x4 interpolation of fs/4 baseband I/Q (two x2 half-band stages),
// then NCO mixing with a quadrant pre-rotation and a 7-stage uncompensated CORDIC.

module fuc_fir #(
    parameter int BW = 12
) (
    input  logic                 clk_fs,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [BW-1:0] din,
    output logic signed [BW-1:0] dout
);
    localparam int AW = BW + 14;
    localparam logic signed [AW-1:0] C0 = AW'(11'sd211);
    localparam logic signed [AW-1:0] C1 = AW'(11'sd420);
    localparam logic signed [AW-1:0] C2 = AW'(11'sd503);
    localparam logic signed [BW-1:0] SMAX = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] SMIN = {1'b1, {(BW-1){1'b0}}};

    logic signed [BW-1:0] tap_r [0:3];
    logic signed [BW-1:0] dout_r;
    logic signed [AW-1:0] acc_s;

    function automatic logic signed [BW-1:0] scale_sat(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] t;
        t = (v >>> 5'd11) <<< 1'b1;
        if ((&t[AW-1:BW-1]) || !(|t[AW-1:BW-1])) begin
            scale_sat = t[BW-1:0];
        end else if (t[AW-1]) begin
            scale_sat = SMIN;
        end else begin
            scale_sat = SMAX;
        end
    endfunction

    // Symmetric coefficients: pair the taps before multiplying
    always_comb begin
        acc_s = '0;
        acc_s = (AW'(din) + AW'(tap_r[3])) * C0
              + (AW'(tap_r[0]) + AW'(tap_r[2])) * C1
              + AW'(tap_r[1]) * C2;
    end

    // Delay line and registered scaled output, advanced only when enabled
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                tap_r[i] <= '0;
            end
            dout_r <= '0;
        end else if (en) begin
            tap_r[0] <= din;
            tap_r[1] <= tap_r[0];
            tap_r[2] <= tap_r[1];
            tap_r[3] <= tap_r[2];
            dout_r   <= scale_sat(acc_s);
        end
    end

    assign dout = dout_r;
endmodule

module fuc #(
    parameter int BW  = 12,
    parameter int ABW = 10
) (
    input  logic                  clk_fs,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [BW-1:0]  Iin,
    input  logic signed [BW-1:0]  Qin,
    input  logic        [ABW-1:0] Wif,
    output logic                  out_valid,
    output logic signed [BW-1:0]  Iout,
    output logic signed [BW-1:0]  Qout,
    output logic                  underrun
);
    localparam int CW = BW + 2;
    localparam int ZW = ABW + 1;
    localparam logic signed [BW-1:0] SMAX = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] SMIN = {1'b1, {(BW-1){1'b0}}};

    logic [1:0]           ph_r;
    logic [ABW-1:0]       theta_r;
    logic [3:0]           vcnt_r;
    logic                 out_valid_r, underrun_r;
    logic signed [BW-1:0] in_i_r, in_q_r;
    logic signed [BW-1:0] f1_in_i_s, f1_in_q_s, f1_i_s, f1_q_s;
    logic signed [BW-1:0] f2_in_i_s, f2_in_q_s, f2_i_s, f2_q_s;
    logic signed [BW-1:0] gi_s, gq_s;
    logic signed [CW-1:0] x_r [0:6];
    logic signed [CW-1:0] y_r [0:6];
    logic signed [ZW-1:0] z_r [0:6];
    logic signed [CW-1:0] xn_s [0:6];
    logic signed [CW-1:0] yn_s [0:6];
    logic signed [ZW-1:0] zn_s [0:5];
    logic signed [BW-1:0] iout_r, qout_r;

    function automatic logic signed [BW-1:0] neg_sat(input logic signed [BW-1:0] v);
        if (v == SMIN) begin
            neg_sat = SMAX;
        end else begin
            neg_sat = -v;
        end
    endfunction

    function automatic logic signed [BW-1:0] sat_cw(input logic signed [CW-1:0] v);
        if ((&v[CW-1:BW-1]) || !(|v[CW-1:BW-1])) begin
            sat_cw = v[BW-1:0];
        end else if (v[CW-1]) begin
            sat_cw = SMIN;
        end else begin
            sat_cw = SMAX;
        end
    endfunction

    // Arctangent table in units where a quarter turn is 256
    function automatic logic signed [ZW-1:0] atan_lut(input int i);
        case (i)
            0:       atan_lut = ZW'(9'sd128);
            1:       atan_lut = ZW'(9'sd76);
            2:       atan_lut = ZW'(9'sd40);
            3:       atan_lut = ZW'(9'sd20);
            4:       atan_lut = ZW'(9'sd10);
            5:       atan_lut = ZW'(9'sd5);
            6:       atan_lut = ZW'(9'sd3);
            default: atan_lut = '0;
        endcase
    endfunction

    assign in_ready  = (ph_r == 2'd0) && !rst;
    assign out_valid = out_valid_r;
    assign underrun  = underrun_r;
    assign Iout      = iout_r;
    assign Qout      = qout_r;

    // Phase counter, sample capture with zero stuffing, NCO and output warm-up
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            ph_r        <= 2'd0;
            theta_r     <= '0;
            vcnt_r      <= 4'd0;
            out_valid_r <= 1'b0;
            underrun_r  <= 1'b0;
            in_i_r      <= '0;
            in_q_r      <= '0;
        end else begin
            ph_r    <= ph_r + 2'd1;
            theta_r <= theta_r + Wif;
            if (ph_r == 2'd0) begin
                in_i_r     <= in_valid ? Iin : '0;
                in_q_r     <= in_valid ? Qin : '0;
                underrun_r <= ~in_valid;
            end else begin
                underrun_r <= 1'b0;
            end
            if (!out_valid_r) begin
                vcnt_r      <= vcnt_r + 4'd1;
                out_valid_r <= (vcnt_r == 4'd10);
            end
        end
    end

    // Zero-stuffing muxes; stage enables are aligned to the delayed phase of each stage
    always_comb begin
        f1_in_i_s = '0;
        f1_in_q_s = '0;
        f2_in_i_s = '0;
        f2_in_q_s = '0;
        if (ph_r == 2'd1) begin
            f1_in_i_s = in_i_r;
            f1_in_q_s = in_q_r;
        end else begin
            f1_in_i_s = '0;
            f1_in_q_s = '0;
        end
        if (!ph_r[0]) begin
            f2_in_i_s = f1_i_s;
            f2_in_q_s = f1_q_s;
        end else begin
            f2_in_i_s = '0;
            f2_in_q_s = '0;
        end
    end

    fuc_fir #(.BW(BW)) u_fir1_i (.clk_fs(clk_fs), .rst(rst), .en(ph_r[0]), .din(f1_in_i_s), .dout(f1_i_s));
    fuc_fir #(.BW(BW)) u_fir1_q (.clk_fs(clk_fs), .rst(rst), .en(ph_r[0]), .din(f1_in_q_s), .dout(f1_q_s));
    fuc_fir #(.BW(BW)) u_fir2_i (.clk_fs(clk_fs), .rst(rst), .en(1'b1),    .din(f2_in_i_s), .dout(f2_i_s));
    fuc_fir #(.BW(BW)) u_fir2_q (.clk_fs(clk_fs), .rst(rst), .en(1'b1),    .din(f2_in_q_s), .dout(f2_q_s));

    // Quadrant pre-rotation leaves the CORDIC less than a quarter turn to cover
    always_comb begin
        gi_s = f2_i_s;
        gq_s = f2_q_s;
        case (theta_r[ABW-1 -: 2])
            2'b00: begin gi_s = f2_i_s;          gq_s = f2_q_s;          end
            2'b01: begin gi_s = neg_sat(f2_q_s); gq_s = f2_i_s;          end
            2'b10: begin gi_s = neg_sat(f2_i_s); gq_s = neg_sat(f2_q_s); end
            2'b11: begin gi_s = f2_q_s;          gq_s = neg_sat(f2_i_s); end
            default: begin gi_s = f2_i_s;        gq_s = f2_q_s;          end
        endcase
    end

    // CORDIC micro-rotations, direction chosen by the residual angle sign
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            xn_s[i] = x_r[i];
            yn_s[i] = y_r[i];
            if (z_r[i][ZW-1]) begin
                xn_s[i] = x_r[i] + (y_r[i] >>> i);
                yn_s[i] = y_r[i] - (x_r[i] >>> i);
            end else begin
                xn_s[i] = x_r[i] - (y_r[i] >>> i);
                yn_s[i] = y_r[i] + (x_r[i] >>> i);
            end
        end
        for (int i = 0; i < 6; i++) begin
            zn_s[i] = z_r[i];
            if (z_r[i][ZW-1]) begin
                zn_s[i] = z_r[i] + atan_lut(i);
            end else begin
                zn_s[i] = z_r[i] - atan_lut(i);
            end
        end
    end

    // Gross-rotation register, CORDIC pipeline and saturated output registers
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                x_r[i] <= '0;
                y_r[i] <= '0;
                z_r[i] <= '0;
            end
            iout_r <= '0;
            qout_r <= '0;
        end else begin
            x_r[0] <= CW'(gi_s);
            y_r[0] <= CW'(gq_s);
            z_r[0] <= {3'b000, theta_r[ABW-3:0]};
            for (int i = 0; i < 6; i++) begin
                x_r[i+1] <= xn_s[i];
                y_r[i+1] <= yn_s[i];
                z_r[i+1] <= zn_s[i];
            end
            iout_r <= sat_cw(xn_s[6]);
            qout_r <= sat_cw(yn_s[6]);
        end
    end
endmodule

// File: tb/tb_fuc.sv
// Randomised self-checking bench for fuc against a cycle-indexed behavioural model:
// sample history -> zero-stuffed convolutions -> angle rotation at the running NCO phase.
module tb_fuc;
    localparam int BW   = 12;
    localparam int ABW  = 10;
    localparam int MAXC = 400;

    logic                  clk_fs = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [BW-1:0]  Iin = '0;
    logic signed [BW-1:0]  Qin = '0;
    logic        [ABW-1:0] Wif = '0;
    logic                  out_valid;
    logic signed [BW-1:0]  Iout;
    logic signed [BW-1:0]  Qout;
    logic                  underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int s_i [0:MAXC/4];
    int s_q [0:MAXC/4];
    int valid_h [0:MAXC-1];
    int wif_h   [0:MAXC-1];
    int theta_h [0:MAXC-1];
    int obs_i   [0:MAXC-1];
    int obs_q   [0:MAXC-1];

    always #5 clk_fs = ~clk_fs;

    fuc #(.BW(BW), .ABW(ABW)) dut (
        .clk_fs(clk_fs), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Iin(Iin), .Qin(Qin), .Wif(Wif), .out_valid(out_valid),
        .Iout(Iout), .Qout(Qout), .underrun(underrun)
    );

    task automatic check_val(input string tag, input int obs, input int expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sat(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int coef(input int j);
        case (j)
            0, 4:    return 211;
            1, 3:    return 420;
            default: return 503;
        endcase
    endfunction

    // floor(acc / 2048) * 2, saturated
    function automatic int fir_scale(input int acc);
        return sat((acc >>> 11) * 2);
    endfunction

    function automatic int samp(input int k, input bit q);
        return q ? s_q[k] : s_i[k];
    endfunction

    // Stage-1 output at half-rate index m: input is samples with a zero between each
    function automatic int f1(input int m, input bit q);
        int acc = 0;
        for (int j = 0; j < 5; j++) begin
            int a = m - j;
            if (a >= 0 && (a % 2) == 0) acc += coef(j) * samp(a / 2, q);
        end
        return fir_scale(acc);
    endfunction

    // Stage-2 output at full-rate index p: input is stage-1 outputs with a zero between each
    function automatic int f2(input int p, input bit q);
        int acc = 0;
        for (int j = 0; j < 5; j++) begin
            int b = p - j;
            if (b >= 0 && (b % 2) == 0) acc += coef(j) * f1(b / 2, q);
        end
        return fir_scale(acc);
    endfunction

    function automatic int neg(input int v);
        return (v == -2048) ? 2047 : -v;
    endfunction

    function automatic int ang(input int i);
        case (i)
            0: return 128;  1: return 76;  2: return 40;  3: return 20;
            4: return 10;   5: return 5;   default: return 3;
        endcase
    endfunction

    task automatic rotate(input int xi, input int yi, input int th, output int xo, output int yo);
        int x, y, z, nx;
        case (th / 256)
            0:       begin x = xi;      y = yi;      end
            1:       begin x = neg(yi); y = xi;      end
            2:       begin x = neg(xi); y = neg(yi); end
            default: begin x = yi;      y = neg(xi); end
        endcase
        z = th % 256;
        for (int i = 0; i < 7; i++) begin
            if (z >= 0) begin
                nx = x - (y >>> i); y = y + (x >>> i); z = z - ang(i);
            end else begin
                nx = x + (y >>> i); y = y - (x >>> i); z = z + ang(i);
            end
            x = nx;
        end
        xo = sat(x);
        yo = sat(y);
    endtask

    // mode 0: Wif=256; 1: impulse; 2: random gaps; 3: -2048 held; 4: Wif=1023; 5: all random
    task automatic run_seg(input int mode, input int len);
        int ii, qq, wif, ei, eq, first, last, peak, qmax, bad;
        bit vld;
        rst = 1'b1; in_valid = 1'b0; Iin = '0; Qin = '0; Wif = '0;
        #1;
        check_val("rst_in_ready", in_ready, 0);
        @(posedge clk_fs); #1;
        check_val("rst_iout", Iout, 0);
        check_val("rst_qout", Qout, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_underrun", underrun, 0);
        check_val("rst_theta", int'(dut.theta_r), 0);
        check_val("rst_in_ready2", in_ready, 0);
        @(posedge clk_fs); #1;
        rst = 1'b0;
        wif = $urandom_range(0, 1023);
        for (int c = 0; c < len; c++) begin
            vld = 1'b1;
            ii  = $urandom_range(0, 4095) - 2048;
            qq  = $urandom_range(0, 4095) - 2048;
            case (mode)
                0: wif = 256;
                1: begin wif = 0; ii = (c == 0) ? 1024 : 0; qq = 0; end
                2: begin
                    vld = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 49) == 0) wif = $urandom_range(0, 1023);
                end
                3: begin wif = 128; ii = -2048; qq = -2048; end
                4: wif = 1023;
                default: begin vld = $urandom_range(0, 1); wif = $urandom_range(0, 1023); end
            endcase
            in_valid = vld; Iin = BW'(ii); Qin = BW'(qq); Wif = ABW'(wif);
            valid_h[c] = vld;
            wif_h[c]   = wif;
            theta_h[c] = (c == 0) ? 0 : (theta_h[c-1] + wif_h[c-1]) % 1024;
            if (c % 4 == 0) begin
                s_i[c/4] = vld ? ii : 0;
                s_q[c/4] = vld ? qq : 0;
            end
            #1;
            ei = 0; eq = 0;
            if (c >= 11) rotate(f2(c - 11, 1'b0), f2(c - 11, 1'b1), theta_h[c-8], ei, eq);
            check_val("iout", Iout, ei);
            check_val("qout", Qout, eq);
            check_val("out_valid", out_valid, (c >= 11) ? 1 : 0);
            check_val("in_ready", in_ready, (c % 4 == 0) ? 1 : 0);
            check_val("underrun", underrun, (c >= 1 && (c - 1) % 4 == 0 && valid_h[c-1] == 0) ? 1 : 0);
            check_val("theta", int'(dut.theta_r), theta_h[c]);
            obs_i[c] = Iout;
            obs_q[c] = Qout;
            @(posedge clk_fs); #1;
        end
        if (mode == 1) begin
            first = -1; last = -1; peak = 0; qmax = 0; bad = 0;
            for (int k = 0; k < len; k++) begin
                if (obs_i[k] != 0) begin
                    if (first < 0) first = k;
                    last = k;
                end
                if (iabs(obs_i[k]) > peak) peak = iabs(obs_i[k]);
                if (iabs(obs_q[k]) > qmax) qmax = iabs(obs_q[k]);
            end
            check_val("imp_latency", first, 11);
            if (first >= 0) begin
                for (int j = 0; j <= last - first; j++) begin
                    if (iabs(obs_i[first + j] - obs_i[last - j]) > 1) bad++;
                end
            end
            check_val("imp_symmetry", bad, 0);
            check_val("imp_q_small", (peak > 0 && qmax * 50 <= peak) ? 1 : 0, 1);
        end
    endtask

    initial begin
        run_seg(0, 48);
        run_seg(1, 48);
        run_seg(3, 80);
        run_seg(4, 48);
        for (int r = 0; r < 3; r++) begin
            run_seg(2, 200);
            run_seg(5, 200);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
